// File: rtl/eth_rx_addr_filter.sv
// RX address/length filter between the MAC RX stream and the RX frame FIFO.
// Marks rejected frames with tuser on tlast and keeps per-cause counters.
module eth_rx_addr_filter #(
  parameter int MIN_HDR_LEN   = 14,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 rx_clk,
  input  logic                 rx_rst,
  input  logic [7:0]           s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  input  logic                 s_axis_tuser,
  output logic [7:0]           m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  input  logic                 cfg_enable,
  input  logic [47:0]          cfg_mac_addr,
  input  logic                 cfg_promisc,
  input  logic                 cfg_accept_bcast,
  input  logic                 cfg_accept_mcast,
  input  logic                 stat_clear,
  output logic [CNT_WIDTH-1:0] stat_accepted,
  output logic [CNT_WIDTH-1:0] stat_addr_drop,
  output logic [CNT_WIDTH-1:0] stat_len_drop,
  output logic                 drop_pulse
);

  typedef enum logic [1:0] {
    IDLE,
    DA,
    PAYLOAD
  } state_t;

  localparam logic [15:0] MIN_L = 16'(MIN_HDR_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_FRAME_LEN);

  state_t      state, state_nxt;
  logic [15:0] byte_cnt, cnt_now;
  logic [47:0] mac_q, mac_e;
  logic        en_q, promisc_q, bcast_q, mcast_q;
  logic        en_e, promisc_e, bcast_e, mcast_e;
  logic        uc_q, bc_q, mc_q;
  logic        uc_now, bc_now, mc_now;
  logic [7:0]  mac_byte;
  logic        idle, sof, last, in_da;
  logic        addr_accept, len_bad, reject;

  // At SOF the shadow regs are not loaded yet, so use live config
  always_comb begin
    idle      = (state == IDLE);
    in_da     = (state != PAYLOAD);
    sof       = s_axis_tvalid & idle;
    last      = s_axis_tvalid & s_axis_tlast;
    en_e      = sof ? cfg_enable       : en_q;
    promisc_e = sof ? cfg_promisc      : promisc_q;
    bcast_e   = sof ? cfg_accept_bcast : bcast_q;
    mcast_e   = sof ? cfg_accept_mcast : mcast_q;
    mac_e     = sof ? cfg_mac_addr     : mac_q;
    case (byte_cnt[2:0])
      3'd0:    mac_byte = mac_e[47:40];
      3'd1:    mac_byte = mac_e[39:32];
      3'd2:    mac_byte = mac_e[31:24];
      3'd3:    mac_byte = mac_e[23:16];
      3'd4:    mac_byte = mac_e[15:8];
      3'd5:    mac_byte = mac_e[7:0];
      default: mac_byte = 8'h00;
    endcase
    if (sof)
      cnt_now = 16'd1;
    else if (&byte_cnt)
      cnt_now = byte_cnt;
    else
      cnt_now = byte_cnt + 16'd1;
    uc_now = uc_q;
    bc_now = bc_q;
    if (in_da) begin
      uc_now = (idle | uc_q) & (s_axis_tdata == mac_byte);
      bc_now = (idle | bc_q) & (s_axis_tdata == 8'hFF);
    end
    mc_now = idle ? s_axis_tdata[0] : mc_q;
    addr_accept = promisc_e | uc_now | (bcast_e & bc_now)
                | (mcast_e & mc_now & ~bc_now);
    len_bad = (cnt_now < MIN_L) | (cnt_now > MAX_L);
    reject  = en_e & (len_bad | ~addr_accept);
  end

  always_comb begin
    state_nxt = state;
    if (s_axis_tvalid) begin
      unique case (state)
        IDLE:    state_nxt = s_axis_tlast ? IDLE : DA;
        DA: begin
          if (s_axis_tlast)
            state_nxt = IDLE;
          else if (byte_cnt == 16'd5)
            state_nxt = PAYLOAD;
        end
        PAYLOAD: if (s_axis_tlast) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      byte_cnt  <= '0;
      mac_q     <= '0;
      en_q      <= 1'b0;
      promisc_q <= 1'b0;
      bcast_q   <= 1'b0;
      mcast_q   <= 1'b0;
      uc_q      <= 1'b0;
      bc_q      <= 1'b0;
      mc_q      <= 1'b0;
    end else if (s_axis_tvalid) begin
      byte_cnt <= s_axis_tlast ? 16'd0 : cnt_now;
      uc_q     <= uc_now;
      bc_q     <= bc_now;
      mc_q     <= mc_now;
      if (sof) begin
        mac_q     <= cfg_mac_addr;
        en_q      <= cfg_enable;
        promisc_q <= cfg_promisc;
        bcast_q   <= cfg_accept_bcast;
        mcast_q   <= cfg_accept_mcast;
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      drop_pulse    <= 1'b0;
    end else begin
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tvalid <= s_axis_tvalid;
      m_axis_tlast  <= s_axis_tlast;
      m_axis_tuser  <= last & (s_axis_tuser | reject);
      drop_pulse    <= last & reject & ~s_axis_tuser;
    end
  end

  // Clear wins over a same-cycle increment
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      stat_accepted  <= '0;
      stat_addr_drop <= '0;
      stat_len_drop  <= '0;
    end else if (stat_clear) begin
      stat_accepted  <= '0;
      stat_addr_drop <= '0;
      stat_len_drop  <= '0;
    end else if (last) begin
      if (reject && len_bad)
        stat_len_drop <= stat_len_drop + CNT_WIDTH'(1);
      else if (reject)
        stat_addr_drop <= stat_addr_drop + CNT_WIDTH'(1);
      else if (!s_axis_tuser)
        stat_accepted <= stat_accepted + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_eth_rx_addr_filter.sv
// Directed bench for eth_rx_addr_filter: frame table plus
// hand sequences for config latching, counter clear and mid-frame reset.
module tb_eth_rx_addr_filter;

  localparam logic [47:0] STA  = 48'h020000000001;
  localparam logic [47:0] OTH  = 48'h020000000002;
  localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MC   = 48'h01005E000001;
  localparam logic [47:0] NEAR = 48'h020000000101;

  logic        rx_clk, rx_rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        cfg_enable, cfg_promisc;
  logic        cfg_accept_bcast, cfg_accept_mcast;
  logic [47:0] cfg_mac_addr;
  logic        stat_clear;
  logic [31:0] stat_accepted, stat_addr_drop, stat_len_drop;
  logic        drop_pulse;

  int tests = 0;
  int fails = 0;

  eth_rx_addr_filter dut (
    .rx_clk          (rx_clk),
    .rx_rst          (rx_rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tlast    (s_axis_tlast),
    .s_axis_tuser    (s_axis_tuser),
    .m_axis_tdata    (m_axis_tdata),
    .m_axis_tvalid   (m_axis_tvalid),
    .m_axis_tlast    (m_axis_tlast),
    .m_axis_tuser    (m_axis_tuser),
    .cfg_enable      (cfg_enable),
    .cfg_mac_addr    (cfg_mac_addr),
    .cfg_promisc     (cfg_promisc),
    .cfg_accept_bcast(cfg_accept_bcast),
    .cfg_accept_mcast(cfg_accept_mcast),
    .stat_clear      (stat_clear),
    .stat_accepted   (stat_accepted),
    .stat_addr_drop  (stat_addr_drop),
    .stat_len_drop   (stat_len_drop),
    .drop_pulse      (drop_pulse)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  typedef struct {
    logic [47:0] da;
    int          len;
    logic        tu;
    logic        pr;
    logic        bc;
    logic        mc;
    logic        en;
    logic        exp_tu;
    logic        exp_drop;
    int          acc;
    int          addr;
    int          lend;
  } vec_t;

  vec_t vt[19];

  task automatic check(input string name, input longint act,
                       input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [47:0] da, input int i);
    if (i < 6)
      return da[47-8*i -: 8];
    return 8'(i * 7 + 3);
  endfunction

  task automatic check_cnt(input string tag, input int a, input int ad,
                           input int l);
    check({tag, " accepted"}, stat_accepted, a);
    check({tag, " addr_drop"}, stat_addr_drop, ad);
    check({tag, " len_drop"}, stat_len_drop, l);
  endtask

  task automatic send_frame(input logic [47:0] da, input int len,
                            input int start, input int stop,
                            input logic tu, input logic exp_tu,
                            input logic exp_drop, input int chg_at,
                            input logic [47:0] chg_addr,
                            input logic clr_last, input string tag);
    int   err;
    logic is_last;
    err = 0;
    for (int i = start; i < stop; i++) begin
      if (i == 8) begin
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        @(posedge rx_clk); #1;
        if (m_axis_tvalid !== 1'b0 || m_axis_tuser !== 1'b0 ||
            drop_pulse !== 1'b0)
          err++;
      end
      if (i == chg_at)
        cfg_mac_addr = chg_addr;
      is_last       = (i == len - 1);
      s_axis_tdata  = fbyte(da, i);
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = is_last;
      s_axis_tuser  = is_last & tu;
      stat_clear    = is_last & clr_last;
      @(posedge rx_clk); #1;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== fbyte(da, i) ||
          m_axis_tlast !== is_last)
        err++;
      if (is_last) begin
        check({tag, " tuser"}, m_axis_tuser, exp_tu);
        check({tag, " drop_pulse"}, drop_pulse, exp_drop);
      end else if (m_axis_tuser !== 1'b0 || drop_pulse !== 1'b0) begin
        err++;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    stat_clear    = 1'b0;
    if (stop == len) begin
      @(posedge rx_clk); #1;
      if (m_axis_tvalid !== 1'b0 || drop_pulse !== 1'b0)
        err++;
    end
    check({tag, " stream"}, err, 0);
  endtask

  initial begin
    vt[0]  = '{STA,  64,   0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    vt[1]  = '{OTH,  64,   0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    vt[2]  = '{OTH,  64,   0, 1, 0, 0, 1, 0, 0, 2, 1, 0};
    vt[3]  = '{BC,   64,   0, 0, 0, 0, 1, 1, 1, 2, 2, 0};
    vt[4]  = '{BC,   64,   0, 0, 1, 0, 1, 0, 0, 3, 2, 0};
    vt[5]  = '{MC,   64,   0, 0, 0, 1, 1, 0, 0, 4, 2, 0};
    vt[6]  = '{MC,   64,   0, 0, 0, 0, 1, 1, 1, 4, 3, 0};
    vt[7]  = '{BC,   64,   0, 0, 0, 1, 1, 1, 1, 4, 4, 0};
    vt[8]  = '{STA,  10,   0, 0, 0, 0, 1, 1, 1, 4, 4, 1};
    vt[9]  = '{STA,  4,    0, 0, 0, 0, 1, 1, 1, 4, 4, 2};
    vt[10] = '{STA,  1519, 0, 0, 0, 0, 1, 1, 1, 4, 4, 3};
    vt[11] = '{STA,  1518, 0, 0, 0, 0, 1, 0, 0, 5, 4, 3};
    vt[12] = '{STA,  14,   0, 0, 0, 0, 1, 0, 0, 6, 4, 3};
    vt[13] = '{STA,  13,   0, 0, 0, 0, 1, 1, 1, 6, 4, 4};
    vt[14] = '{STA,  64,   1, 0, 0, 0, 1, 1, 0, 6, 4, 4};
    vt[15] = '{OTH,  10,   0, 0, 0, 0, 0, 0, 0, 7, 4, 4};
    vt[16] = '{OTH,  64,   1, 0, 0, 0, 1, 1, 0, 7, 5, 4};
    vt[17] = '{NEAR, 64,   0, 0, 0, 0, 1, 1, 1, 7, 6, 4};
    vt[18] = '{STA,  1,    0, 0, 0, 0, 1, 1, 1, 7, 6, 5};

    rx_rst           = 1'b1;
    s_axis_tdata     = '0;
    s_axis_tvalid    = 1'b0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;
    cfg_enable       = 1'b1;
    cfg_mac_addr     = STA;
    cfg_promisc      = 1'b0;
    cfg_accept_bcast = 1'b0;
    cfg_accept_mcast = 1'b0;
    stat_clear       = 1'b0;
    repeat (3) @(posedge rx_clk);
    #1;
    check("rst tvalid", m_axis_tvalid, 0);
    check("rst tuser", m_axis_tuser, 0);
    check("rst drop_pulse", drop_pulse, 0);
    check_cnt("rst", 0, 0, 0);
    rx_rst = 1'b0;
    @(posedge rx_clk); #1;

    for (int k = 0; k < 19; k++) begin
      cfg_mac_addr     = STA;
      cfg_promisc      = vt[k].pr;
      cfg_accept_bcast = vt[k].bc;
      cfg_accept_mcast = vt[k].mc;
      cfg_enable       = vt[k].en;
      send_frame(vt[k].da, vt[k].len, 0, vt[k].len, vt[k].tu,
                 vt[k].exp_tu, vt[k].exp_drop, -1, STA, 1'b0,
                 $sformatf("v%0d", k));
      check_cnt($sformatf("v%0d", k), vt[k].acc, vt[k].addr, vt[k].lend);
    end

    // Address change mid-frame must not affect the frame in flight
    cfg_enable       = 1'b1;
    cfg_promisc      = 1'b0;
    cfg_accept_bcast = 1'b0;
    cfg_accept_mcast = 1'b0;
    send_frame(STA, 64, 0, 64, 0, 0, 0, 3, OTH, 1'b0, "cfgchg");
    cfg_mac_addr = STA;
    check_cnt("cfgchg", 8, 6, 5);

    stat_clear = 1'b1;
    @(posedge rx_clk); #1;
    stat_clear = 1'b0;
    check_cnt("clear", 0, 0, 0);
    send_frame(STA, 64, 0, 64, 0, 0, 0, -1, STA, 1'b1, "clrlast");
    check_cnt("clrlast", 0, 0, 0);
    send_frame(STA, 64, 0, 64, 0, 0, 0, -1, STA, 1'b0, "postclr");
    check_cnt("postclr", 1, 0, 0);

    // Reset after byte 20, then the rest of that frame and a fresh one
    send_frame(STA, 64, 0, 20, 0, 0, 0, -1, STA, 1'b0, "prerst");
    rx_rst = 1'b1;
    #2;
    check("inrst tvalid", m_axis_tvalid, 0);
    check("inrst tdata", m_axis_tdata, 0);
    check_cnt("inrst", 0, 0, 0);
    repeat (2) @(posedge rx_clk);
    #1;
    rx_rst = 1'b0;
    send_frame(STA, 64, 20, 64, 0, 1, 1, -1, STA, 1'b0, "frag");
    check_cnt("frag", 0, 1, 0);
    send_frame(STA, 64, 0, 64, 0, 0, 0, -1, STA, 1'b0, "fresh");
    check_cnt("fresh", 1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
